// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the CPU execute stage and a debug/display port share
// one set of byte-lane banks; debug wins when the CPU is idle or after a bounded wait.
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [15:0] STALL_SAT  = 16'hFFFF
) (
    input  logic        sysclk,
    input  logic        cpu_resetn,
    input  logic        cpu_req,
    input  logic [3:0]  cpu_wren,
    input  logic [7:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [7:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic [7:0]  mem_addr,
    output logic [3:0]  mem_wren,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] stall_cnt
);

    typedef enum logic {ARB, DBG_ACK} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    logic [3:0]  starve;
    logic [15:0] stall_q;
    logic        dbg_elig;
    logic        dbg_grant;

    function automatic logic [15:0] stall_sat_inc(input logic [15:0] v);
        return (v == STALL_SAT) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] starve_sat_inc(input logic [3:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
    endfunction

    // Debug is held ineligible during reset so a CPU access still reaches memory.
    assign dbg_elig  = cpu_resetn && (state == ARB) && dbg_req;
    assign dbg_grant = dbg_elig && (!cpu_req || (starve == STARVE_LIM));
    assign cpu_stall = cpu_req && dbg_grant;
    assign cpu_rdata = mem_rdata;
    assign stall_cnt = stall_q;

    always_comb begin
        mem_addr  = '0;
        mem_wren  = '0;
        mem_wdata = '0;
        if (dbg_grant) begin
            mem_addr  = dbg_addr;
            mem_wren  = dbg_we ? 4'b1111 : 4'b0000;
            mem_wdata = dbg_wdata;
        end else if (cpu_req) begin
            mem_addr  = cpu_addr;
            mem_wren  = cpu_wren;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state     <= ARB;
            starve    <= '0;
            stall_q   <= '0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= dbg_grant;
            state   <= dbg_grant ? DBG_ACK : ARB;
            if (dbg_grant && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end
            // Only losses taken in ARB count toward starvation; DBG_ACK cycles hold.
            if (dbg_grant || !dbg_req) begin
                starve <= '0;
            end else if (state == ARB) begin
                starve <= starve_sat_inc(starve);
            end
            if (cpu_stall) begin
                stall_q <= stall_sat_inc(stall_q);
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle table plus hand-written sequences for
// debug turnaround, reset during the ack cycle and stall-counter saturation.
module tb_dmem_arbiter;

    logic        sysclk = 1'b0;
    logic        cpu_resetn;
    logic        cpu_req;
    logic [3:0]  cpu_wren;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_wren;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] stall_cnt;

    logic [31:0] s_cpu_rdata;
    logic        s_cpu_stall;
    logic        s_dbg_ack;
    logic [31:0] s_dbg_rdata;
    logic [7:0]  s_mem_addr;
    logic [3:0]  s_mem_wren;
    logic [31:0] s_mem_wdata;
    logic [15:0] s_stall_cnt;

    int checks = 0;
    int errors = 0;

    logic        mem_init = 1'b0;
    logic [31:0] mem [256];

    always #5 sysclk = ~sysclk;

    dmem_arbiter #(.STARVE_MAX(4)) dut (
        .sysclk(sysclk), .cpu_resetn(cpu_resetn),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    // Small ceiling so counter saturation is reachable in a short run.
    dmem_arbiter #(.STARVE_MAX(1), .STALL_SAT(16'd3)) dut_sat (
        .sysclk(sysclk), .cpu_resetn(cpu_resetn),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(s_dbg_ack), .dbg_rdata(s_dbg_rdata),
        .mem_addr(s_mem_addr), .mem_wren(s_mem_wren), .mem_wdata(s_mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(s_stall_cnt)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge sysclk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h90] <= 32'd97;
            mem[8'h10] <= 32'h1122_3344;
        end else begin
            for (int l = 0; l < 4; l++)
                if (mem_wren[l]) mem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
    end

    typedef struct {
        logic        creq;
        logic [3:0]  cwren;
        logic [7:0]  caddr;
        logic [31:0] cwdata;
        logic        dreq;
        logic        dwe;
        logic [7:0]  daddr;
        logic [31:0] dwdata;
        logic [7:0]  e_maddr;
        logic [3:0]  e_mwren;
        logic [31:0] e_mwdata;
        logic        e_stall;
        logic        e_ack;
        logic [31:0] e_crdata;
        logic [31:0] e_drdata;
        logic [15:0] e_scnt;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic creq, input logic [7:0] caddr, input logic dreq,
                         input logic dwe, input logic [7:0] daddr, input logic [31:0] dwdata);
        cpu_req   = creq;
        cpu_wren  = 4'b0000;
        cpu_addr  = caddr;
        cpu_wdata = 32'h0;
        dbg_req   = dreq;
        dbg_we    = dwe;
        dbg_addr  = daddr;
        dbg_wdata = dwdata;
    endtask

    initial begin
        tbl[0]  = '{0, 4'h0, 8'h00, 32'h0,         0, 0, 8'h00, 32'h0,
                    8'h00, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,         16'd0};
        tbl[1]  = '{1, 4'h3, 8'h10, 32'hAABBCCDD,  0, 0, 8'h00, 32'h0,
                    8'h10, 4'h3, 32'hAABBCCDD,  0, 0, 32'h11223344,  32'h0,         16'd0};
        tbl[2]  = '{1, 4'h0, 8'h10, 32'h0,         0, 0, 8'h00, 32'h0,
                    8'h10, 4'h0, 32'h0,         0, 0, 32'h1122CCDD,  32'h0,         16'd0};
        tbl[3]  = '{0, 4'h0, 8'h00, 32'h0,         1, 0, 8'h90, 32'h0,
                    8'h90, 4'h0, 32'h0,         0, 0, 32'd97,        32'h0,         16'd0};
        tbl[4]  = '{0, 4'h0, 8'h00, 32'h0,         1, 0, 8'h90, 32'h0,
                    8'h00, 4'h0, 32'h0,         0, 1, 32'h0,         32'd97,        16'd0};
        tbl[5]  = '{0, 4'h0, 8'h00, 32'h0,         1, 1, 8'h20, 32'h12345678,
                    8'h20, 4'hF, 32'h12345678,  0, 0, 32'h0,         32'd97,        16'd0};
        tbl[6]  = '{1, 4'h0, 8'h20, 32'h0,         0, 0, 8'h00, 32'h0,
                    8'h20, 4'h0, 32'h0,         0, 1, 32'h12345678,  32'd97,        16'd0};
        for (int i = 7; i <= 10; i++)
            tbl[i] = '{1, 4'h0, 8'h90, 32'h0,      1, 0, 8'h10, 32'h0,
                       8'h90, 4'h0, 32'h0,      0, 0, 32'd97,        32'd97,        16'd0};
        tbl[11] = '{1, 4'h0, 8'h90, 32'h0,         1, 0, 8'h10, 32'h0,
                    8'h10, 4'h0, 32'h0,         1, 0, 32'h1122CCDD,  32'd97,        16'd0};
        tbl[12] = '{1, 4'h0, 8'h90, 32'h0,         1, 0, 8'h10, 32'h0,
                    8'h90, 4'h0, 32'h0,         0, 1, 32'd97,        32'h1122CCDD,  16'd1};
        tbl[13] = '{0, 4'h0, 8'h00, 32'h0,         0, 0, 8'h00, 32'h0,
                    8'h00, 4'h0, 32'h0,         0, 0, 32'h0,         32'h1122CCDD,  16'd1};
        tbl[14] = '{1, 4'h0, 8'h90, 32'h0,         1, 0, 8'h10, 32'h0,
                    8'h90, 4'h0, 32'h0,         0, 0, 32'd97,        32'h1122CCDD,  16'd1};
        tbl[15] = '{1, 4'h0, 8'h90, 32'h0,         0, 0, 8'h00, 32'h0,
                    8'h90, 4'h0, 32'h0,         0, 0, 32'd97,        32'h1122CCDD,  16'd1};
        tbl[16] = '{0, 4'h0, 8'h00, 32'h0,         0, 0, 8'h00, 32'h0,
                    8'h00, 4'h0, 32'h0,         0, 0, 32'h0,         32'h1122CCDD,  16'd1};

        // Reset state; a CPU access still reaches memory while debug is locked out.
        cpu_resetn = 1'b0;
        drive(1'b1, 8'h10, 1'b1, 1'b0, 8'h90, 32'h0);
        @(posedge sysclk);
        #1 mem_init = 1'b1;
        #1;
        chk("rst_ack",    {31'h0, dbg_ack},   32'h0);
        chk("rst_drdata", dbg_rdata,          32'h0);
        chk("rst_scnt",   {16'h0, stall_cnt}, 32'h0);
        chk("rst_maddr",  {24'h0, mem_addr},  32'h10);
        chk("rst_stall",  {31'h0, cpu_stall}, 32'h0);
        chk("rst_crdata", cpu_rdata,          32'h11223344);
        @(negedge sysclk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        cpu_resetn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge sysclk);
            cpu_req   = tbl[i].creq;
            cpu_wren  = tbl[i].cwren;
            cpu_addr  = tbl[i].caddr;
            cpu_wdata = tbl[i].cwdata;
            dbg_req   = tbl[i].dreq;
            dbg_we    = tbl[i].dwe;
            dbg_addr  = tbl[i].daddr;
            dbg_wdata = tbl[i].dwdata;
            #1;
            chk($sformatf("v%0d_maddr", i),  {24'h0, mem_addr},   {24'h0, tbl[i].e_maddr});
            chk($sformatf("v%0d_mwren", i),  {28'h0, mem_wren},   {28'h0, tbl[i].e_mwren});
            chk($sformatf("v%0d_mwdata", i), mem_wdata,           tbl[i].e_mwdata);
            chk($sformatf("v%0d_stall", i),  {31'h0, cpu_stall},  {31'h0, tbl[i].e_stall});
            chk($sformatf("v%0d_ack", i),    {31'h0, dbg_ack},    {31'h0, tbl[i].e_ack});
            chk($sformatf("v%0d_crdata", i), cpu_rdata,           tbl[i].e_crdata);
            chk($sformatf("v%0d_drdata", i), dbg_rdata,           tbl[i].e_drdata);
            chk($sformatf("v%0d_scnt", i),   {16'h0, stall_cnt},  {16'h0, tbl[i].e_scnt});
        end

        // Back-to-back debug writes: grant and ack alternate, no writes in ack cycles.
        for (int k = 0; k < 6; k++) begin
            @(negedge sysclk);
            drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 32'h5A5A5A5A);
            #1;
            chk($sformatf("b2b%0d_ack", k),   {31'h0, dbg_ack},  (k % 2 == 1) ? 32'h1 : 32'h0);
            chk($sformatf("b2b%0d_mwren", k), {28'h0, mem_wren}, (k % 2 == 0) ? 32'hF : 32'h0);
            chk($sformatf("b2b%0d_maddr", k), {24'h0, mem_addr}, (k % 2 == 0) ? 32'h30 : 32'h0);
        end
        @(negedge sysclk);
        drive(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("b2b_crdata", cpu_rdata,         32'h5A5A5A5A);
        chk("b2b_ack_end", {31'h0, dbg_ack}, 32'h0);

        // Starvation under continuous CPU traffic: debug granted on the 5th cycle.
        for (int k = 0; k < 5; k++) begin
            @(negedge sysclk);
            drive(1'b1, 8'h90, 1'b1, 1'b0, 8'h10, 32'h0);
            #1;
            chk($sformatf("stv%0d_stall", k), {31'h0, cpu_stall}, (k == 4) ? 32'h1 : 32'h0);
            chk($sformatf("stv%0d_maddr", k), {24'h0, mem_addr},  (k == 4) ? 32'h10 : 32'h90);
        end
        @(negedge sysclk);
        chk("stv_ack_pending", {31'h0, dbg_ack},   32'h1);
        chk("stv_scnt",        {16'h0, stall_cnt}, 32'h2);
        // Reset lands in the ack cycle: the ack and all state must clear at once.
        cpu_resetn = 1'b0;
        #1;
        chk("rda_ack",    {31'h0, dbg_ack},   32'h0);
        chk("rda_scnt",   {16'h0, stall_cnt}, 32'h0);
        chk("rda_drdata", dbg_rdata,          32'h0);
        chk("rda_maddr",  {24'h0, mem_addr},  32'h90);
        chk("rda_stall",  {31'h0, cpu_stall}, 32'h0);
        @(negedge sysclk);
        cpu_resetn = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 32'h0);
        #1;
        chk("rda_regrant_maddr", {24'h0, mem_addr}, 32'h10);
        @(negedge sysclk);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("rda_regrant_ack",    {31'h0, dbg_ack},   32'h1);
        chk("rda_regrant_drdata", dbg_rdata,          32'h1122CCDD);
        chk("rda_regrant_scnt",   {16'h0, stall_cnt}, 32'h0);

        // Stall counter saturation (small ceiling instance) under sustained contention.
        @(negedge sysclk);
        cpu_resetn = 1'b0;
        @(negedge sysclk);
        cpu_resetn = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge sysclk);
            drive(1'b1, 8'h90, 1'b1, 1'b0, 8'h10, 32'h0);
            #1;
            if (c == 6) chk("sat_mid", {16'h0, s_stall_cnt}, 32'h2);
        end
        @(negedge sysclk);
        #1;
        chk("sat_hold", {16'h0, s_stall_cnt}, 32'h3);
        chk("sat_main", {16'h0, stall_cnt},   32'h2);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge sysclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive lost debug arbitration cycles that forces a debug grant (legal range 1..15).
REQ-002 sysclk  input  1  clock; all state updates on the rising edge.
REQ-003 cpu_resetn  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req  input  1  execute-stage memory access this cycle (load or store).
REQ-005 cpu_wren  input  4  per-byte write enables, bit i selects byte lane i (bits 8i+7:8i).
REQ-006 cpu_addr  input  8  word address (byte address >>> 2, low 8 bits).
REQ-007 cpu_wdata  input  32  store data.
REQ-008 cpu_rdata  output  32  load data, combinational from mem_rdata.
REQ-009 cpu_stall  output  1  CPU access not serviced this cycle; the pipeline holds the execute stage.
REQ-010 dbg_req  input  1  debug/display port request, level, held until dbg_ack.
REQ-011 dbg_we  input  1  debug write (all 4 lanes) when 1, read when 0.
REQ-012 dbg_addr  input  8  debug word address, stable while dbg_req is high.
REQ-013 dbg_wdata  input  32  debug write data.
REQ-014 dbg_ack  output  1  registered one-cycle completion pulse.
REQ-015 dbg_rdata  output  32  registered read data, valid while dbg_ack=1 and held until the next debug grant.
REQ-016 mem_addr  output  8  address to the four byte-lane memory banks.
REQ-017 mem_wren  output  4  per-lane write enables to the banks.
REQ-018 mem_wdata  output  32  write data to the banks.
REQ-019 mem_rdata  input  32  combinational read data from the banks.
REQ-020 stall_cnt  output  16  saturating count of cycles with cpu_stall=1.

Function
REQ-021 The arbiter SHALL be a two-state FSM: ARB and DBG_ACK.
REQ-022 In ARB, the debug port is eligible when dbg_req=1; in DBG_ACK it is not eligible.
REQ-023 Grant rule per cycle: debug wins if eligible and (cpu_req=0 or starve=STARVE_MAX); otherwise the CPU wins if cpu_req=1; otherwise there is no grant.
REQ-024 CPU grant: mem_addr=cpu_addr, mem_wren=cpu_wren, mem_wdata=cpu_wdata, cpu_stall=0; all combinational in the same cycle.
REQ-025 Debug grant: mem_addr=dbg_addr, mem_wren=dbg_we?4'b1111:4'b0000, mem_wdata=dbg_wdata; dbg_rdata<=mem_rdata on a read; state->DBG_ACK; dbg_ack=1 in the next cycle.
REQ-026 No grant: mem_wren=0, mem_addr=0, mem_wdata=0.
REQ-027 cpu_stall=1 exactly when cpu_req=1 and debug is granted; it is never 1 when cpu_req=0.
REQ-028 cpu_rdata SHALL equal mem_rdata at all times; it is only meaningful when cpu_stall=0.
REQ-029 DBG_ACK->ARB unconditionally after one cycle; the CPU may be granted during DBG_ACK.
REQ-030 A 4-bit starve counter SHALL increment, saturating at STARVE_MAX, each cycle dbg_req=1 in ARB without a debug grant.
REQ-031 The starve counter SHALL clear on a debug grant, and also when dbg_req=0.
REQ-032 Debug latency is 1 cycle from grant to ack when uncontended; worst case is STARVE_MAX+1 cycles under continuous cpu_req.
REQ-033 Consecutive debug transactions are granted at most every 2nd cycle, because of the DBG_ACK turnaround.
REQ-034 stall_cnt SHALL increment by 1 per stalled cycle and hold at 16'hFFFF.
REQ-035 If dbg_req drops before grant, no access or ack occurs and the request is abandoned silently.

Reset
REQ-036 When cpu_resetn=0, state=ARB, starve=0, stall_cnt=0, dbg_ack=0, and dbg_rdata=0, asynchronously.
REQ-037 Reset asserted while the FSM is in DBG_ACK SHALL suppress the pending dbg_ack.
REQ-038 Combinational outputs SHALL follow REQ-023..026 during reset with debug ineligible, so a CPU request still reaches memory.

Verification
REQ-039 Idle CPU, debug read addr 8'h90 (bank content 32'd97): grant -> next cycle dbg_ack=1, dbg_rdata=97, cpu_stall never 1.
REQ-040 cpu_req held high, STARVE_MAX=4, dbg_req raised at cycle 0: debug granted at cycle 4; cpu_stall=1 for that cycle only; dbg_ack at cycle 5; stall_cnt=1.
REQ-041 CPU store cpu_wren=4'b0011, addr 8'h10, data 32'hAABBCCDD over existing 32'h11223344 -> subsequent CPU read returns 32'h1122CCDD.
REQ-042 dbg_req held high continuously with cpu_req=0: acks occur every other cycle; mem_wren=0 in all DBG_ACK cycles unless the CPU requests.
REQ-043 cpu_resetn pulsed low during DBG_ACK: dbg_ack stays 0, stall_cnt=0, starve=0, and the FSM returns to ARB.
REQ-044 Force 65,536 stalled cycles: stall_cnt saturates at 16'hFFFF and does not wrap.
